// File: rtl/pmem_arbiter.sv
// Round-robin arbiter sharing one physical memory port between the I-cache and D-cache.
// The granted command is latched so the memory sees a stable request for the whole service.
module pmem_arbiter (
    input  logic         clk,
    input  logic         reset_n,

    input  logic         i_pmem_read,
    input  logic [15:0]  i_pmem_address,
    output logic [127:0] i_pmem_rdata,
    output logic         i_pmem_resp,

    input  logic         d_pmem_read,
    input  logic         d_pmem_write,
    input  logic [15:0]  d_pmem_address,
    input  logic [127:0] d_pmem_wdata,
    output logic [127:0] d_pmem_rdata,
    output logic         d_pmem_resp,

    output logic         pmem_read,
    output logic         pmem_write,
    output logic [15:0]  pmem_address,
    output logic [127:0] pmem_wdata,
    input  logic [127:0] pmem_rdata,
    input  logic         pmem_resp
);

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D
    } state_t;

    state_t        state;
    logic          last_grant;
    logic [15:0]   addr_q;
    logic [127:0]  wdata_q;
    logic          rd_q;
    logic          wr_q;

    logic          i_req;
    logic          d_req;
    logic          grant_i;
    logic          grant_d;

    assign i_req   = i_pmem_read;
    assign d_req   = d_pmem_read | d_pmem_write;
    // On a tie the client not named by last_grant wins
    assign grant_i = i_req & (~d_req | last_grant);
    assign grant_d = d_req & (~i_req | ~last_grant);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_i) begin
                        state      <= SERVE_I;
                        last_grant <= 1'b0;
                        addr_q     <= i_pmem_address;
                        rd_q       <= 1'b1;
                        wr_q       <= 1'b0;
                    end else if (grant_d) begin
                        state      <= SERVE_D;
                        last_grant <= 1'b1;
                        addr_q     <= d_pmem_address;
                        wdata_q    <= d_pmem_wdata;
                        // A simultaneous read and write is taken as a write-back only
                        rd_q       <= ~d_pmem_write;
                        wr_q       <= d_pmem_write;
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (pmem_resp) begin
                        state <= IDLE;
                        rd_q  <= 1'b0;
                        wr_q  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    rd_q  <= 1'b0;
                    wr_q  <= 1'b0;
                end
            endcase
        end
    end

    assign pmem_read    = rd_q;
    assign pmem_write   = wr_q;
    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;

    assign i_pmem_resp  = pmem_resp & (state == SERVE_I);
    assign d_pmem_resp  = pmem_resp & (state == SERVE_D);
    assign i_pmem_rdata = pmem_rdata;
    assign d_pmem_rdata = pmem_rdata;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench for pmem_arbiter: arbitration order, latched commands, response gating, reset.
module tb_pmem_arbiter;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         i_pmem_read;
    logic [15:0]  i_pmem_address;
    logic [127:0] i_pmem_rdata;
    logic         i_pmem_resp;
    logic         d_pmem_read;
    logic         d_pmem_write;
    logic [15:0]  d_pmem_address;
    logic [127:0] d_pmem_wdata;
    logic [127:0] d_pmem_rdata;
    logic         d_pmem_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    pmem_arbiter dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .i_pmem_read    (i_pmem_read),
        .i_pmem_address (i_pmem_address),
        .i_pmem_rdata   (i_pmem_rdata),
        .i_pmem_resp    (i_pmem_resp),
        .d_pmem_read    (d_pmem_read),
        .d_pmem_write   (d_pmem_write),
        .d_pmem_address (d_pmem_address),
        .d_pmem_wdata   (d_pmem_wdata),
        .d_pmem_rdata   (d_pmem_rdata),
        .d_pmem_resp    (d_pmem_resp),
        .pmem_read      (pmem_read),
        .pmem_write     (pmem_write),
        .pmem_address   (pmem_address),
        .pmem_wdata     (pmem_wdata),
        .pmem_rdata     (pmem_rdata),
        .pmem_resp      (pmem_resp)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string tag, input string nm, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s.%s: observed %b expected %b", tag, nm, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input string nm, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s.%s: observed %h expected %h", tag, nm, obs, exp);
        end
    endtask

    task automatic chk128(input string tag, input string nm, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s.%s: observed %h expected %h", tag, nm, obs, exp);
        end
    endtask

    // Called on the first negedge after a grant; memory answers after lat wait cycles.
    task automatic serve(input string tag, input logic [15:0] a, input logic rd, input logic wr,
                         input logic is_d, input int unsigned lat, input logic [127:0] wd,
                         input logic [127:0] data);
        for (int unsigned k = 0; k <= lat; k++) begin
            if (k == lat) begin
                pmem_resp  = 1'b1;
                pmem_rdata = data;
            end
            #1;
            chk1(tag, "pmem_read", pmem_read, rd);
            chk1(tag, "pmem_write", pmem_write, wr);
            chk16(tag, "pmem_address", pmem_address, a);
            if (wr) chk128(tag, "pmem_wdata", pmem_wdata, wd);
            chk1(tag, "i_pmem_resp", i_pmem_resp, (k == lat) && !is_d);
            chk1(tag, "d_pmem_resp", d_pmem_resp, (k == lat) && is_d);
            if (k == lat) begin
                if (is_d) chk128(tag, "d_pmem_rdata", d_pmem_rdata, data);
                else      chk128(tag, "i_pmem_rdata", i_pmem_rdata, data);
            end else begin
                @(negedge clk);
            end
        end
    endtask

    // Checks the mandatory IDLE cycle, then moves to the negedge after the next grant edge.
    task automatic idle_gap(input string tag);
        @(negedge clk);
        pmem_resp = 1'b0;
        #1;
        chk1(tag, "idle_read", pmem_read, 1'b0);
        chk1(tag, "idle_write", pmem_write, 1'b0);
        chk1(tag, "idle_iresp", i_pmem_resp, 1'b0);
        chk1(tag, "idle_dresp", d_pmem_resp, 1'b0);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $error("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n        = 1'b0;
        i_pmem_read    = 1'b1;
        i_pmem_address = 16'h0abc;
        d_pmem_read    = 1'b0;
        d_pmem_write   = 1'b0;
        d_pmem_address = '0;
        d_pmem_wdata   = '0;
        pmem_rdata     = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
        pmem_resp      = 1'b1;

        // Reset: outputs zero, rdata broadcast, requests ignored
        @(negedge clk);
        #1;
        chk1("rst", "pmem_read", pmem_read, 1'b0);
        chk1("rst", "pmem_write", pmem_write, 1'b0);
        chk16("rst", "pmem_address", pmem_address, 16'h0000);
        chk128("rst", "pmem_wdata", pmem_wdata, '0);
        chk1("rst", "i_pmem_resp", i_pmem_resp, 1'b0);
        chk1("rst", "d_pmem_resp", d_pmem_resp, 1'b0);
        chk128("rst", "i_pmem_rdata", i_pmem_rdata, 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210);
        chk128("rst", "d_pmem_rdata", d_pmem_rdata, 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210);

        // Simultaneous requests after reset: I first, D after an IDLE cycle
        @(negedge clk);
        reset_n        = 1'b1;
        pmem_resp      = 1'b0;
        i_pmem_address = 16'h0040;
        d_pmem_read    = 1'b1;
        d_pmem_address = 16'h8000;
        @(negedge clk);
        serve("t43i", 16'h0040, 1'b1, 1'b0, 1'b0, 1, '0, {4{32'h1111_0040}});
        i_pmem_read = 1'b0;
        idle_gap("t43i");
        serve("t43d", 16'h8000, 1'b1, 1'b0, 1'b1, 0, '0, {4{32'h2222_8000}});
        d_pmem_read = 1'b0;
        idle_gap("t43d");

        // Continuous ties alternate I, D, I, D
        i_pmem_read    = 1'b1;
        i_pmem_address = 16'h1111;
        d_pmem_read    = 1'b1;
        d_pmem_address = 16'h2222;
        @(negedge clk);
        serve("t44a", 16'h1111, 1'b1, 1'b0, 1'b0, 0, '0, {8{16'hA001}});
        idle_gap("t44a");
        serve("t44b", 16'h2222, 1'b1, 1'b0, 1'b1, 1, '0, {8{16'hB002}});
        idle_gap("t44b");
        serve("t44c", 16'h1111, 1'b1, 1'b0, 1'b0, 0, '0, {8{16'hA003}});
        idle_gap("t44c");
        serve("t44d", 16'h2222, 1'b1, 1'b0, 1'b1, 0, '0, {8{16'hB004}});
        i_pmem_read = 1'b0;
        d_pmem_read = 1'b0;
        idle_gap("t44d");

        // I-only read with a 3-cycle memory
        i_pmem_read    = 1'b1;
        i_pmem_address = 16'h1230;
        @(negedge clk);
        serve("t42", 16'h1230, 1'b1, 1'b0, 1'b0, 3, '0, {4{32'hDEAD_BEEF}});
        i_pmem_read = 1'b0;
        idle_gap("t42");

        // D write-back, I arrives mid-service and wins the following fill tie
        d_pmem_write   = 1'b1;
        d_pmem_address = 16'h2000;
        d_pmem_wdata   = {16{8'hA5}};
        @(negedge clk);
        i_pmem_read    = 1'b1;
        i_pmem_address = 16'h0100;
        d_pmem_wdata   = {16{8'h5A}};
        serve("t45w", 16'h2000, 1'b0, 1'b1, 1'b1, 2, {16{8'hA5}}, '0);
        d_pmem_write   = 1'b0;
        d_pmem_read    = 1'b1;
        d_pmem_address = 16'h3000;
        idle_gap("t45w");
        serve("t45i", 16'h0100, 1'b1, 1'b0, 1'b0, 1, '0, {4{32'h0000_0100}});
        i_pmem_read = 1'b0;
        idle_gap("t45i");
        serve("t45r", 16'h3000, 1'b1, 1'b0, 1'b1, 0, '0, {4{32'h0000_3000}});
        d_pmem_read = 1'b0;
        idle_gap("t45r");

        // Client address change after grant does not reach memory
        d_pmem_read    = 1'b1;
        d_pmem_address = 16'h4000;
        @(negedge clk);
        d_pmem_address = 16'h5000;
        serve("t46", 16'h4000, 1'b1, 1'b0, 1'b1, 2, '0, {4{32'h0000_4000}});
        d_pmem_read = 1'b0;
        idle_gap("t46");

        // Stray pmem_resp in IDLE is ignored
        pmem_resp = 1'b1;
        #1;
        chk1("t35", "i_pmem_resp", i_pmem_resp, 1'b0);
        chk1("t35", "d_pmem_resp", d_pmem_resp, 1'b0);
        @(negedge clk);
        pmem_resp = 1'b0;
        #1;
        chk1("t35", "pmem_read", pmem_read, 1'b0);

        // Read and write together latch a write only
        d_pmem_read    = 1'b1;
        d_pmem_write   = 1'b1;
        d_pmem_address = 16'h7000;
        d_pmem_wdata   = {16{8'hC3}};
        @(negedge clk);
        serve("t24", 16'h7000, 1'b0, 1'b1, 1'b1, 1, {16{8'hC3}}, '0);
        d_pmem_read  = 1'b0;
        d_pmem_write = 1'b0;
        idle_gap("t24");

        // Reset during SERVE_D aborts without a response, then I wins the fresh tie
        d_pmem_read    = 1'b1;
        d_pmem_address = 16'h6000;
        @(negedge clk);
        #1;
        chk1("t47", "pre_read", pmem_read, 1'b1);
        reset_n   = 1'b0;
        pmem_resp = 1'b1;
        #1;
        chk1("t47", "pmem_read", pmem_read, 1'b0);
        chk1("t47", "pmem_write", pmem_write, 1'b0);
        chk1("t47", "d_pmem_resp", d_pmem_resp, 1'b0);
        chk16("t47", "pmem_address", pmem_address, 16'h0000);
        i_pmem_read    = 1'b1;
        i_pmem_address = 16'h0300;
        @(negedge clk);
        reset_n   = 1'b1;
        pmem_resp = 1'b0;
        @(negedge clk);
        serve("t41", 16'h0300, 1'b1, 1'b0, 1'b0, 0, '0, {4{32'h0000_0300}});
        i_pmem_read = 1'b0;
        idle_gap("t41");
        serve("t41d", 16'h6000, 1'b1, 1'b0, 1'b1, 0, '0, {4{32'h0000_6000}});
        d_pmem_read = 1'b0;
        idle_gap("t41d");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pmem_arbiter.md
PMEM_ARBITER -- requirements
Module: pmem_arbiter

Interface
REQ-001 The block SHALL have ports `clk`, input, 1 bit: the single clock, with all state changing on its rising edge.
REQ-002 The block SHALL have port `reset_n`, input, 1 bit: reset is asynchronous and active-low.
REQ-003 The block SHALL have port `i_pmem_read`, input, 1 bit: I-cache line-fill request.
REQ-004 The block SHALL have port `i_pmem_address`, input, lc3b_word (16 bits): I-cache line address.
REQ-005 The block SHALL have port `i_pmem_rdata`, output, lc3b_128: line data returned to the I-cache.
REQ-006 The block SHALL have port `i_pmem_resp`, output, 1 bit: I-cache transfer done.
REQ-007 The block SHALL have ports `d_pmem_read` and `d_pmem_write`, input, 1 bit each: D-cache fill and write-back requests.
REQ-008 The block SHALL have port `d_pmem_address`, input, lc3b_word: D-cache line address.
REQ-009 The block SHALL have port `d_pmem_wdata`, input, lc3b_128: D-cache write-back line.
REQ-010 The block SHALL have port `d_pmem_rdata`, output, lc3b_128: line data returned to the D-cache.
REQ-011 The block SHALL have port `d_pmem_resp`, output, 1 bit: D-cache transfer done.
REQ-012 The block SHALL have ports `pmem_read` and `pmem_write`, output, 1 bit each: physical memory commands.
REQ-013 The block SHALL have port `pmem_address`, output, lc3b_word: physical memory line address.
REQ-014 The block SHALL have port `pmem_wdata`, output, lc3b_128: write data to physical memory.
REQ-015 The block SHALL have ports `pmem_rdata` (lc3b_128) and `pmem_resp` (1 bit), inputs: physical memory return data and completion.

Function
REQ-016 The block SHALL implement a state machine with states IDLE, SERVE_I and SERVE_D, plus a 1-bit register `last_grant` (0 = I, 1 = D).
REQ-017 In IDLE with only the I-cache requesting, the block SHALL go to SERVE_I on the next edge.
REQ-018 In IDLE with only the D-cache requesting, the block SHALL go to SERVE_D on the next edge.
REQ-019 In IDLE with both caches requesting, the block SHALL grant the client that is not named by `last_grant` (round-robin).
REQ-020 On every grant the block SHALL update `last_grant` to the granted client.
REQ-021 On a grant edge the block SHALL latch the command into internal registers: address, operation, and wdata (wdata for D only).
REQ-022 `pmem_address`, `pmem_wdata`, `pmem_read` and `pmem_write` SHALL be driven only from the latched registers, so they are stable for the whole service.
REQ-023 The latched command SHALL be unaffected by any client input changes after the grant.
REQ-024 If `d_pmem_read` and `d_pmem_write` are both 1 at grant, the block SHALL latch a write only.
REQ-025 In SERVE_I the block SHALL drive `pmem_read` = 1 and `pmem_write` = 0.
REQ-026 In SERVE_D exactly one of `pmem_read` and `pmem_write` SHALL be 1, per the latched operation.
REQ-027 In IDLE the block SHALL drive `pmem_read` and `pmem_write` to 0.
REQ-028 `i_pmem_resp` SHALL equal `pmem_resp` AND (state == SERVE_I), combinationally, with zero added latency.
REQ-029 `d_pmem_resp` SHALL equal `pmem_resp` AND (state == SERVE_D), combinationally, with zero added latency.
REQ-030 A non-granted client SHALL never see a response asserted.
REQ-031 `i_pmem_rdata` and `d_pmem_rdata` SHALL both equal `pmem_rdata` combinationally (broadcast); only the resp signal qualifies which client consumes it.
REQ-032 In a SERVE state with `pmem_resp` = 1, the block SHALL return to IDLE on the next edge.
REQ-033 The block SHALL always spend one IDLE cycle between services, so that a requester can drop its request after its response.
REQ-034 A client that deasserts its request mid-service SHALL be ignored; the service SHALL complete on `pmem_resp`.
REQ-035 A `pmem_resp` that arrives in IDLE SHALL be ignored: no client response is asserted and the state does not change.
REQ-036 A D-cache write-back followed by a fill (back-to-back requests) SHALL be treated as two independent arbitrations.
REQ-037 If the I-cache is waiting when the write-back completes, the I-cache SHALL win the arbitration for the fill.

Reset
REQ-038 While `reset_n` = 0, the state SHALL be IDLE and `last_grant` SHALL be 1, so the I-cache wins the first tie.
REQ-039 While `reset_n` = 0, the latched address and wdata SHALL be 0 and all outputs SHALL be 0, except the rdata outputs, which follow `pmem_rdata`.
REQ-040 If reset is asserted mid-service, the block SHALL abort at once, with no client response issued.
REQ-041 After reset is released, the block SHALL arbitrate afresh from IDLE.

Verification
REQ-042 I-only read: I-cache requests address 0x1230 and memory responds after 3 cycles with data D. Required: `pmem_read` = 1 and `pmem_address` = 0x1230 for 3 cycles, `i_pmem_resp` = 1 for 1 cycle with `i_pmem_rdata` = D, and `d_pmem_resp` = 0 throughout.
REQ-043 Simultaneous requests after reset: I requests 0x0040 and D requests a read of 0x8000 on the same cycle. Required: I is served first; D is granted after one IDLE cycle with `pmem_address` = 0x8000.
REQ-044 Repeated ties: both caches request continuously for 4 transfers. Required: the grant order is I, D, I, D.
REQ-045 D write-back then fill: `d_pmem_write` with wdata 0xA5..A5 at 0x2000, then `d_pmem_read` at 0x3000, while the I-cache is pending. Required: write 0x2000, then I fill, then D read 0x3000; `pmem_wdata` stays stable during the write.
REQ-046 Input change mid-service: the D address changes from 0x4000 to 0x5000 after the grant. Required: `pmem_address` stays 0x4000 until `pmem_resp`.
REQ-047 Reset mid-service: `reset_n` is pulsed low during SERVE_D. Required: `pmem_read`/`pmem_write` go to 0 immediately, no `d_pmem_resp` is issued, and IDLE is entered.
